// File: rtl/branch_cond_unit_if.sv
// Branch condition unit bus: flag write port, evaluation request handshake,
// counter control, and result/statistics outputs.
interface branch_cond_unit_if #(
    parameter int CNT_W = 16
);
    // Flag write port
    logic             flag_we;
    logic             alu_zero;
    logic             alu_neg;
    logic             alu_ovf;

    // Evaluation request and control
    logic             eval_req;
    logic [2:0]       cond_sel;
    logic             flush;
    logic             cnt_clr;

    // Results and status
    logic             eval_ready;
    logic             cond_valid;
    logic             cond_taken;
    logic             flags_valid;
    logic [CNT_W-1:0] eval_cnt;
    logic [CNT_W-1:0] taken_cnt;

    // Requester side: drives flags and requests, observes results
    modport master (
        output flag_we, alu_zero, alu_neg, alu_ovf,
        output eval_req, cond_sel, flush, cnt_clr,
        input  eval_ready, cond_valid, cond_taken, flags_valid,
        input  eval_cnt, taken_cnt
    );

    // Unit side
    modport slave (
        input  flag_we, alu_zero, alu_neg, alu_ovf,
        input  eval_req, cond_sel, flush, cnt_clr,
        output eval_ready, cond_valid, cond_taken, flags_valid,
        output eval_cnt, taken_cnt
    );
endinterface

// File: rtl/branch_cond_unit.sv
// Branch condition unit: holds the ALU flags, evaluates a 3-bit condition code
// against them (waiting for fresh flags if none are held), and emits a
// one-cycle result pulse. Two saturating counters track results produced and
// results taken.
module branch_cond_unit #(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    branch_cond_unit_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FLAGS = 2'd1,
        RESULT     = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t     state_reg, state_next;
    logic       zero_reg, zero_next;
    logic       neg_reg, neg_next;
    logic       ovf_reg, ovf_next;
    logic       fv_reg, fv_next;
    logic [2:0] sel_reg, sel_next;
    logic       taken_reg, taken_next;
    logic       enter_result;

    // Flags seen by an evaluation this cycle: incoming ALU flags bypass the
    // register when they are being written in the same cycle.
    logic       eff_zero, eff_neg, eff_ovf;

    // Condition code evaluation; lt is signed less-than from neg/ovf.
    function automatic logic eval_cond(input logic [2:0] sel, input logic z,
                                       input logic n, input logic v);
        logic lt;
        lt = n ^ v;
        case (sel)
            3'b000:  eval_cond = z;
            3'b001:  eval_cond = !z;
            3'b010:  eval_cond = !z && !lt;
            3'b011:  eval_cond = z || lt;
            3'b100:  eval_cond = lt;
            3'b101:  eval_cond = !lt;
            3'b110:  eval_cond = 1'b1;
            default: eval_cond = 1'b0;
        endcase
    endfunction

    // Flag bypass selection
    always_comb begin
        eff_zero = bus.flag_we ? bus.alu_zero : zero_reg;
        eff_neg  = bus.flag_we ? bus.alu_neg  : neg_reg;
        eff_ovf  = bus.flag_we ? bus.alu_ovf  : ovf_reg;
    end

    // Next-state, flag register and result computation
    always_comb begin
        state_next   = state_reg;
        zero_next    = zero_reg;
        neg_next     = neg_reg;
        ovf_next     = ovf_reg;
        fv_next      = fv_reg;
        sel_next     = sel_reg;
        taken_next   = 1'b0;
        enter_result = 1'b0;

        // Any flag write is latched regardless of state; what differs per
        // state is whether the flags are consumed (flags_valid cleared) or
        // left pending.
        if (bus.flag_we) begin
            zero_next = bus.alu_zero;
            neg_next  = bus.alu_neg;
            ovf_next  = bus.alu_ovf;
        end

        case (state_reg)
            IDLE: begin
                if (bus.eval_req) begin
                    sel_next = bus.cond_sel;
                    if (fv_reg || bus.flag_we) begin
                        state_next   = RESULT;
                        enter_result = 1'b1;
                        fv_next      = 1'b0;
                        taken_next   = eval_cond(bus.cond_sel, eff_zero, eff_neg, eff_ovf);
                    end else begin
                        state_next = WAIT_FLAGS;
                    end
                end else if (bus.flag_we) begin
                    fv_next = 1'b1;
                end
            end
            WAIT_FLAGS: begin
                if (bus.flush) begin
                    // Abort wins over arriving flags; those stay pending.
                    state_next = IDLE;
                    if (bus.flag_we) begin
                        fv_next = 1'b1;
                    end
                end else if (bus.flag_we) begin
                    state_next   = RESULT;
                    enter_result = 1'b1;
                    fv_next      = 1'b0;
                    taken_next   = eval_cond(sel_reg, bus.alu_zero, bus.alu_neg, bus.alu_ovf);
                end
            end
            RESULT: begin
                // Single-cycle result; requests are not accepted here.
                state_next = IDLE;
                if (bus.flag_we) begin
                    fv_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM state, flag register, captured condition and result register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            zero_reg  <= 1'b0;
            neg_reg   <= 1'b0;
            ovf_reg   <= 1'b0;
            fv_reg    <= 1'b0;
            sel_reg   <= 3'b000;
            taken_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            zero_reg  <= zero_next;
            neg_reg   <= neg_next;
            ovf_reg   <= ovf_next;
            fv_reg    <= fv_next;
            sel_reg   <= sel_next;
            taken_reg <= taken_next;
        end
    end

    // Statistics counters: index 0 counts results, index 1 counts taken
    // results. Both advance on the edge that produces the result so the
    // counts already include it while cond_valid is high.
    logic [CNT_W-1:0] cnt_reg  [2];
    logic [CNT_W-1:0] cnt_next [2];
    logic             cnt_inc  [2];

    always_comb begin
        cnt_inc[0] = enter_result;
        cnt_inc[1] = enter_result && taken_next;
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            // Clear beats increment; increment holds at all-ones
            always_comb begin
                cnt_next[gi] = cnt_reg[gi];
                if (bus.cnt_clr) begin
                    cnt_next[gi] = '0;
                end else if (cnt_inc[gi] && (cnt_reg[gi] != CNT_MAX)) begin
                    cnt_next[gi] = cnt_reg[gi] + CNT_ONE;
                end
            end

            // Counter register
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt_reg[gi] <= '0;
                end else begin
                    cnt_reg[gi] <= cnt_next[gi];
                end
            end
        end
    endgenerate

    // Outputs decoded from registered state
    always_comb begin
        bus.eval_ready  = (state_reg == IDLE);
        bus.cond_valid  = (state_reg == RESULT);
        bus.cond_taken  = (state_reg == RESULT) && taken_reg;
        bus.flags_valid = fv_reg;
        bus.eval_cnt    = cnt_reg[0];
        bus.taken_cnt   = cnt_reg[1];
    end
endmodule

// File: doc/branch_cond_unit.md
BRANCH_COND_UNIT -- requirements
Module: branch_cond_unit

Interface
REQ-001 Parameter CNT_W, default 16: width of the statistics counters (legal range 1..32).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; clears all state immediately when low.
REQ-004 flag_we  input  1  latch alu_zero/alu_neg/alu_ovf into the flag register this cycle.
REQ-005 alu_zero  input  1  ALU result equals zero.
REQ-006 alu_neg  input  1  ALU result MSB.
REQ-007 alu_ovf  input  1  ALU signed overflow.
REQ-008 eval_req  input  1  request a condition evaluation; accepted only when eval_ready=1.
REQ-009 cond_sel  input  3  condition code; sampled only at acceptance.
REQ-010 flush  input  1  synchronous abort of any pending evaluation.
REQ-011 cnt_clr  input  1  synchronous clear of both statistics counters.
REQ-012 eval_ready  output  1  high in IDLE only.
REQ-013 cond_valid  output  1  one-cycle pulse carrying the result.
REQ-014 cond_taken  output  1  evaluated condition; 0 whenever cond_valid=0.
REQ-015 flags_valid  output  1  flag register holds unconsumed flags.
REQ-016 eval_cnt  output  CNT_W  number of results produced, saturating.
REQ-017 taken_cnt  output  CNT_W  number of results with cond_taken=1, saturating.

Function
REQ-018 lt = neg XOR ovf (signed less-than); the unit SHALL evaluate cond_sel as: 000 EQ=z, 001 NE=!z, 010 GT=!z&!lt, 011 LE=z|lt, 100 LT=lt, 101 GE=!lt, 110 ALWAYS=1, 111 NEVER=0.
REQ-019 The FSM SHALL have three states: IDLE, WAIT_FLAGS, RESULT; cond_valid=1 exactly while in RESULT.
REQ-020 IDLE, eval_req=1 and (flags_valid=1 or flag_we=1): capture cond_sel, go to RESULT; with flag_we=1 the incoming ALU inputs SHALL be used (bypass) and also written to the flag register.
REQ-021 IDLE, eval_req=1, flags_valid=0, flag_we=0: capture cond_sel, go to WAIT_FLAGS.
REQ-022 WAIT_FLAGS, flag_we=1: latch flags, go to RESULT evaluating the newly latched flags with the captured cond_sel.
REQ-023 RESULT SHALL last exactly one cycle then return to IDLE; eval_req in RESULT is not accepted.
REQ-024 Latency: result appears the cycle after the flags are available (1 cycle from accepted eval_req with valid flags).
REQ-025 flags_valid SHALL clear on every transition into RESULT; it SHALL set on flag_we in any other case (IDLE without acceptance, RESULT).
REQ-026 flush=1 in WAIT_FLAGS SHALL return to IDLE with no result and no counter change; flush in IDLE/RESULT has no effect; flush does not alter the flag register or flags_valid.
REQ-027 flush and flag_we simultaneous in WAIT_FLAGS: flush wins, flags latched, flags_valid=1.
REQ-028 On each RESULT cycle eval_cnt SHALL increment and taken_cnt SHALL increment if cond_taken=1; each holds at 2^CNT_W-1 (no wrap).
REQ-029 cnt_clr SHALL zero both counters next cycle and takes priority over a same-cycle increment.

Reset
REQ-030 While reset=0: state IDLE, flag register 0, flags_valid=0, cond_valid=0, cond_taken=0, captured cond_sel 0, both counters 0; eval_ready=1.
REQ-031 Reset asserted mid-evaluation (WAIT_FLAGS or RESULT) SHALL discard it with no output pulse after release.

Verification
REQ-032 flag_we with z=1, next cycle eval_req cond_sel=000 -> one cycle later cond_valid=1, cond_taken=1, eval_cnt=1, taken_cnt=1, flags_valid=0.
REQ-033 IDLE, eval_req cond_sel=010 with flag_we same cycle, z=0 neg=1 ovf=1 (lt=0) -> next cycle cond_valid=1, cond_taken=1.
REQ-034 eval_req cond_sel=100 with flags_valid=0 -> WAIT_FLAGS, eval_ready=0; 3 idle cycles; flag_we neg=1 ovf=0 -> next cycle cond_taken=1.
REQ-035 eval_req in WAIT_FLAGS then flush -> eval_ready=1 next cycle, no cond_valid, eval_cnt unchanged.
REQ-036 CNT_W=2, four ALWAYS evaluations -> eval_cnt=3, taken_cnt=3; cnt_clr with a fifth RESULT -> both 0.
REQ-037 reset low during RESULT -> cond_valid=0 immediately, counters 0, eval_ready=1 after release.
